// File: rtl/frame_buffer_reader_pkg.sv
// Shared timing constants, frame buffer geometry and the pixel type used by the
// frame buffer read-side scanner.
package frame_buffer_reader_pkg;

  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int unsigned FB_W   = 320;
  localparam int unsigned FB_H   = 240;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CNT_W  = 10;

  typedef logic [11:0] rgb444_t;

  // 2x upscale: (v/2)*320 + h/2, built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] v);
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    x = {{(ADDR_W - CNT_W + 1){1'b0}}, h[CNT_W-1:1]};
    y = {{(ADDR_W - CNT_W + 1){1'b0}}, v[CNT_W-1:1]};
    return (y << 8) + (y << 6) + x;
  endfunction

endpackage

// File: rtl/frame_buffer_reader_timing.sv
// Horizontal/vertical scan counters with the raw (undelayed) active flag, sync levels
// and frame wrap strobe, all decoded combinationally from the current counter values.
module frame_buffer_reader_timing
  import frame_buffer_reader_pkg::*;
#(
  parameter int unsigned HVis  = H_VIS,
  parameter int unsigned HFp   = H_FP,
  parameter int unsigned HSync = H_SYNC,
  parameter int unsigned HBp   = H_BP,
  parameter int unsigned VVis  = V_VIS,
  parameter int unsigned VFp   = V_FP,
  parameter int unsigned VSync = V_SYNC,
  parameter int unsigned VBp   = V_BP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hsync_raw_o,
  output logic             vsync_raw_o,
  output logic             frame_wrap_o
);

  localparam int unsigned HTotal = HVis + HFp + HSync + HBp;
  localparam int unsigned VTotal = VVis + VFp + VSync + VBp;

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_end, v_end;

  always_comb begin
    h_end = (h_q == CNT_W'(HTotal - 1));
    v_end = (v_q == CNT_W'(VTotal - 1));
    h_d   = h_end ? '0 : h_q + 1'b1;
    v_d   = v_q;
    if (h_end) begin
      v_d = v_end ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_cnt_o      = h_q;
    v_cnt_o      = v_q;
    active_o     = (h_q < CNT_W'(HVis)) && (v_q < CNT_W'(VVis));
    hsync_raw_o  = !((h_q >= CNT_W'(HVis + HFp)) && (h_q < CNT_W'(HVis + HFp + HSync)));
    vsync_raw_o  = !((v_q >= CNT_W'(VVis + VFp)) && (v_q < CNT_W'(VVis + VFp + VSync)));
    frame_wrap_o = h_end && v_end;
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// QVGA frame buffer read-side scanner: 640x480@60 VGA timing, 2x-upscaled buffer reads,
// and sync/DE realigned with the one-cycle buffer read latency.
module frame_buffer_reader
  import frame_buffer_reader_pkg::*;
#(
  parameter int unsigned HVis  = H_VIS,
  parameter int unsigned HFp   = H_FP,
  parameter int unsigned HSync = H_SYNC,
  parameter int unsigned HBp   = H_BP,
  parameter int unsigned VVis  = V_VIS,
  parameter int unsigned VFp   = V_FP,
  parameter int unsigned VSync = V_SYNC,
  parameter int unsigned VBp   = V_BP
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rAddr,
  output logic              oe,
  input  logic [DATA_W-1:0] rData,
  output logic              h_sync,
  output logic              v_sync,
  output logic              de,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              frame_start
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hsync_raw, vsync_raw, frame_wrap;

  frame_buffer_reader_timing #(
    .HVis  (HVis),
    .HFp   (HFp),
    .HSync (HSync),
    .HBp   (HBp),
    .VVis  (VVis),
    .VFp   (VFp),
    .VSync (VSync),
    .VBp   (VBp)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (reset),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .active_o     (active),
    .hsync_raw_o  (hsync_raw),
    .vsync_raw_o  (vsync_raw),
    .frame_wrap_o (frame_wrap)
  );

  // Stage 1 issues the read; stage 2 lines up with rData coming back from the buffer.
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic              de_q, de_d;
  logic              hs2_q, hs2_d;
  logic              vs2_q, vs2_d;
  logic              fs_q, fs_d;

  always_comb begin
    oe_d    = active;
    raddr_d = active ? fb_addr(h_cnt, v_cnt) : '0;
    hs1_d   = hsync_raw;
    vs1_d   = vsync_raw;
    de_d    = oe_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    fs_d    = frame_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_q    <= 1'b0;
      raddr_q <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      de_q    <= 1'b0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      oe_q    <= oe_d;
      raddr_q <= raddr_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      de_q    <= de_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      fs_q    <= fs_d;
    end
  end

  rgb444_t rgb;

  always_comb begin
    rgb         = de_q ? rgb444_t'(rData) : '0;
    rAddr       = raddr_q;
    oe          = oe_q;
    h_sync      = hs2_q;
    v_sync      = vs2_q;
    de          = de_q;
    frame_start = fs_q;
    red         = rgb[11:8];
    green       = rgb[7:4];
    blue        = rgb[3:0];
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader with a shortened vertical frame so several
// whole frames fit in a short run; horizontal timing is the full 800-clock line.
module tb_frame_buffer_reader;

  localparam int unsigned TVVis    = 8;
  localparam int unsigned TVFp     = 2;
  localparam int unsigned TVSync   = 2;
  localparam int unsigned TVBp     = 3;
  localparam int unsigned TVTotal  = 15;
  localparam int unsigned HTot     = 800;
  localparam int unsigned FrameClk = HTot * TVTotal;
  localparam int          MaxErr   = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] rAddr;
  logic        oe;
  logic [11:0] rData = 12'hFFF;
  logic        h_sync, v_sync, de;
  logic [3:0]  red, green, blue;
  logic        frame_start;

  always #20 clk = ~clk;

  frame_buffer_reader #(
    .VVis  (TVVis),
    .VFp   (TVFp),
    .VSync (TVSync),
    .VBp   (TVBp)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rAddr       (rAddr),
    .oe          (oe),
    .rData       (rData),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .de          (de),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start)
  );

  // Buffer model: 1-clk read latency, mem[a] = a % 4096, all-ones when not enabled.
  always @(posedge clk) rData <= oe ? rAddr[11:0] : 12'hFFF;

  typedef struct packed {
    logic        oe;
    logic [16:0] addr;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        fs;
  } obs_t;

  typedef struct {
    int s;
    int addr;
  } addr_vec_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;
  int   n = 0;
  int   rh = 0, rv = 0;
  int   hits = 0;
  int   pulses = 0;
  int   last_fs = 0;

  // Directed read addresses: state index s = v*800 + h of the counter that issued them.
  addr_vec_t vecs[12] = '{
    '{0, 0}, '{1, 0}, '{2, 1}, '{3, 1}, '{639, 319}, '{640, 0}, '{800, 0},
    '{1439, 319}, '{1600, 320}, '{1602, 321}, '{3200, 640}, '{6239, 1279}
  };

  function automatic void next_hv(input int h, input int v, output int nh, output int nv);
    nh = h + 1;
    nv = v;
    if (h == HTot - 1) begin
      nh = 0;
      nv = (v == TVTotal - 1) ? 0 : v + 1;
    end
  endfunction

  // Expected outputs two clocks after the counter sits at (h,v).
  function automatic obs_t model(input int h, input int v);
    obs_t o;
    int h1, v1, h2, v2;
    next_hv(h, v, h1, v1);
    next_hv(h1, v1, h2, v2);
    o.de   = (h < 640) && (v < TVVis);
    o.hs   = !((h >= 656) && (h < 752));
    o.vs   = !((v >= 10) && (v < 12));
    o.rgb  = o.de ? 12'(((v / 2) * 320 + h / 2) % 4096) : 12'h000;
    o.oe   = (h1 < 640) && (v1 < TVVis);
    o.addr = o.oe ? 17'((v1 / 2) * 320 + h1 / 2) : 17'd0;
    o.fs   = (h2 == 0) && (v2 == 0);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " oe"}, 32'(oe), 32'd0);
    chk({tag, " rAddr"}, 32'(rAddr), 32'd0);
    chk({tag, " h_sync"}, 32'(h_sync), 32'd1);
    chk({tag, " v_sync"}, 32'(v_sync), 32'd1);
    chk({tag, " de"}, 32'(de), 32'd0);
    chk({tag, " rgb"}, 32'({red, green, blue}), 32'd0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
  endtask

  task automatic start_scan();
    exp_q.delete();
    rh = 0;
    rv = 0;
    n = 0;
    hits = 0;
    pulses = 0;
    last_fs = 0;
    reset = 1'b0;
    exp_q.push_back(model(0, 0));
    run = 1'b1;
  endtask

  // Stimulus side: advance the reference counter and queue its expected response.
  always @(posedge clk) begin
    #1;
    if (run) begin
      n++;
      next_hv(rh, rv, rh, rv);
      exp_q.push_back(model(rh, rv));
    end
  end

  // Monitor side: pop and compare every output cycle once the pipeline has filled.
  always @(negedge clk) begin
    obs_t a, e;
    if (run && n >= 2) begin
      a.oe   = oe;
      a.addr = rAddr;
      a.de   = de;
      a.hs   = h_sync;
      a.vs   = v_sync;
      a.rgb  = {red, green, blue};
      a.fs   = frame_start;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: output present but queue empty", n);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: got oe=%b addr=%0d de=%b hs=%b vs=%b rgb=%h fs=%b, expected oe=%b addr=%0d de=%b hs=%b vs=%b rgb=%h fs=%b",
                   n, a.oe, a.addr, a.de, a.hs, a.vs, a.rgb, a.fs,
                   e.oe, e.addr, e.de, e.hs, e.vs, e.rgb, e.fs);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run && n >= 1) begin
      foreach (vecs[i]) begin
        if (vecs[i].s == n - 1) begin
          hits++;
          chk($sformatf("rAddr at s=%0d", vecs[i].s), 32'(rAddr), 32'(vecs[i].addr));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run && frame_start) begin
      pulses++;
      chk("frame_start spacing", 32'(n - last_fs), 32'(FrameClk));
      last_fs = n;
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    @(negedge clk);
    start_scan();
    repeat (1000) @(posedge clk);
    #2;
    run = 1'b0;
    reset = 1'b1;
    #1;
    check_reset("mid-line");
    chk("frame_start before first wrap", 32'(pulses), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset("held");

    @(negedge clk);
    start_scan();
    for (int c = 0; c < 3 * FrameClk + 100; c++) begin
      @(posedge clk);
      if (errors >= MaxErr) break;
    end
    @(negedge clk);
    run = 1'b0;
    chk("directed address hits", 32'(hits), 32'(12));
    chk("frame_start pulses in 3 frames", 32'(pulses), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
